// File: rtl/approx_mult_pkg.sv
// Shared types and helpers for the approximate sequential multiplier.
// Holds the FSM state type, the accuracy-control width and the k clamp.
package approx_mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_K_W   = $clog2(DEFAULT_WIDTH + 1);

    // Depths beyond the operand width carry no extra meaning, so saturate at w.
    function automatic int unsigned clamp_k(input int unsigned k, input int unsigned w);
        return (k > w) ? w : k;
    endfunction

endpackage

// File: rtl/approx_adder_row.sv
// W-bit ripple adder row; masked columns bypass the cell with an OR and kill the carry.
module approx_adder_row #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [WIDTH-1:0] approx_mask,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] cell_sum;
    logic [WIDTH-1:0] cell_carry;

    assign carry[0] = 1'b0;

    for (genvar j = 0; j < WIDTH; j++) begin : g_col
        bit_addition_logic u_cell (
            .a     (x[j]),
            .b     (y[j]),
            .cin   (carry[j]),
            .sum   (cell_sum[j]),
            .carry (cell_carry[j])
        );

        assign sum[j]     = approx_mask[j] ? (x[j] | y[j]) : cell_sum[j];
        assign carry[j+1] = approx_mask[j] ? 1'b0 : cell_carry[j];
    end

    assign cout = carry[WIDTH];

endmodule

// File: rtl/bit_addition_logic.sv
// One-bit full-adder cell used as the exact column of every adder row.
module bit_addition_logic (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b ^ cin;
    assign carry = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/approx_seq_multiplier.sv
// Shift-and-add multiplier, one partial-product row per cycle, with run-time
// approximation of the k lowest-weight columns.
module approx_seq_multiplier
    import approx_mult_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int K_W   = $clog2(WIDTH + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [K_W-1:0]     acc_k,
    output logic               ready,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CNT_W = $clog2(WIDTH);

    // Handshake: start is accepted on a rising edge where ready=1; done is a
    // single-cycle pulse in the cycle product first shows the new result.
    state_t             state;
    state_t             state_next;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic [K_W-1:0]     k_r;
    logic [CNT_W-1:0]   iter;
    logic [2*WIDTH:0]   acc;
    logic [2*WIDTH:0]   acc_next;
    logic [WIDTH-1:0]   row;
    logic [WIDTH-1:0]   row_sum;
    logic               row_cout;
    logic [WIDTH-1:0]   approx_mask;
    logic               last_iter;
    logic               unused_acc_bits;

    assign last_iter = (iter == CNT_W'(WIDTH - 1));
    assign row       = b_r[iter] ? a_r : '0;

    // Column j of this row carries absolute weight iter+j.
    always_comb begin
        approx_mask = '0;
        for (int j = 0; j < WIDTH; j++) begin
            approx_mask[j] = (int'(iter) + j) < int'(k_r);
        end
    end

    approx_adder_row #(.WIDTH(WIDTH)) u_row (
        .x           (acc[2*WIDTH-1:WIDTH]),
        .y           (row),
        .approx_mask (approx_mask),
        .sum         (row_sum),
        .cout        (row_cout)
    );

    assign acc_next        = {1'b0, row_cout, row_sum, acc[WIDTH-1:1]};
    assign unused_acc_bits = ^{acc[2*WIDTH], acc[0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_iter) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        ready = (state == IDLE);
        done  = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r     <= '0;
            b_r     <= '0;
            k_r     <= '0;
            iter    <= '0;
            acc     <= '0;
            product <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_r  <= a;
                        b_r  <= b;
                        k_r  <= K_W'(clamp_k(int'(acc_k), WIDTH));
                        iter <= '0;
                        acc  <= '0;
                    end
                end
                RUN: begin
                    acc  <= acc_next;
                    iter <= iter + CNT_W'(1);
                    // Load on the edge that enters DONE so done and product align.
                    if (last_iter) begin
                        product <= acc_next[2*WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
